// File: rtl/mem_port_arbiter.sv
// Shares the byte-wide memory bus between instruction fetch and data memory, serialising
// 32-bit little-endian words into byte transfers. Optional IF flush: define MEM_ARB_IF_FLUSH_EN.
module mem_port_arbiter #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IDLE_ADDR  = '0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  if_req_in,
  input  logic [ADDR_WIDTH-1:0] if_addr_in,
`ifdef MEM_ARB_IF_FLUSH_EN
  input  logic                  if_flush_in,
`endif
  output logic                  if_done_o,
  output logic [31:0]           if_inst_o,
  input  logic                  dm_req_in,
  input  logic                  dm_we_in,
  input  logic [1:0]            dm_len_in,
  input  logic [ADDR_WIDTH-1:0] dm_addr_in,
  input  logic [31:0]           dm_wdata_in,
  output logic                  dm_done_o,
  output logic [31:0]           dm_rdata_o,
  output logic                  busy_o,
  input  logic [7:0]            mem_din_in,
  output logic [7:0]            mem_dout_o,
  output logic [ADDR_WIDTH-1:0] mem_a_o,
  output logic                  mem_wr_o
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t                state;
  logic [CNT_W-1:0]      issue_cnt;
  logic [CNT_W-1:0]      cap_cnt;
  logic [CNT_W-1:0]      len_n;
  logic                  cap_arm;
  logic                  src_dm;
  logic [ADDR_WIDTH-1:0] base;
  logic [WORD_W-1:0]     wdata;
  logic [WORD_W-1:0]     word_buf;

  logic [CNT_W-1:0]      dm_len_n_c;
  logic [ADDR_WIDTH-1:0] next_addr_c;
  logic [BYTE_W-1:0]     issue_byte_c;
  logic [WORD_W-1:0]     cap_word_c;
  logic                  if_flush_c;

`ifdef MEM_ARB_IF_FLUSH_EN
  assign if_flush_c = if_flush_in;
`else
  assign if_flush_c = 1'b0;
`endif

  // Byte count decode, next byte address/data and the word with the current read byte merged in
  always_comb begin
    dm_len_n_c = CNT_W'(4);
    case (dm_len_in)
      2'd0:    dm_len_n_c = CNT_W'(1);
      2'd1:    dm_len_n_c = CNT_W'(2);
      default: dm_len_n_c = CNT_W'(4);
    endcase
    next_addr_c  = base + ADDR_WIDTH'(issue_cnt);
    issue_byte_c = BYTE_W'(wdata >> {issue_cnt[1:0], 3'b000});
    cap_word_c   = word_buf | (WORD_W'(mem_din_in) << {cap_cnt[1:0], 3'b000});
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      issue_cnt  <= '0;
      cap_cnt    <= '0;
      len_n      <= '0;
      cap_arm    <= 1'b0;
      src_dm     <= 1'b0;
      base       <= '0;
      wdata      <= '0;
      word_buf   <= '0;
      mem_a_o    <= IDLE_ADDR;
      mem_wr_o   <= 1'b0;
      mem_dout_o <= '0;
      if_done_o  <= 1'b0;
      dm_done_o  <= 1'b0;
      if_inst_o  <= '0;
      dm_rdata_o <= '0;
      busy_o     <= 1'b0;
    end else if (rdy_in) begin
      if_done_o <= 1'b0;
      dm_done_o <= 1'b0;
      case (state)
        IDLE: begin
          // DM wins a tie; the first address goes out on the acceptance edge
          if (dm_req_in) begin
            src_dm    <= 1'b1;
            base      <= dm_addr_in;
            len_n     <= dm_len_n_c;
            wdata     <= dm_wdata_in;
            issue_cnt <= CNT_W'(1);
            cap_cnt   <= '0;
            cap_arm   <= 1'b0;
            word_buf  <= '0;
            mem_a_o   <= dm_addr_in;
            busy_o    <= 1'b1;
            if (dm_we_in) begin
              state      <= WR;
              mem_wr_o   <= 1'b1;
              mem_dout_o <= dm_wdata_in[7:0];
            end else begin
              state <= RD;
            end
          end else if (if_req_in && !if_flush_c) begin
            src_dm    <= 1'b0;
            base      <= if_addr_in;
            len_n     <= CNT_W'(4);
            wdata     <= '0;
            issue_cnt <= CNT_W'(1);
            cap_cnt   <= '0;
            cap_arm   <= 1'b0;
            word_buf  <= '0;
            mem_a_o   <= if_addr_in;
            busy_o    <= 1'b1;
            state     <= RD;
          end
        end
        RD: begin
          if (if_flush_c && !src_dm) begin
            state     <= IDLE;
            mem_a_o   <= IDLE_ADDR;
            busy_o    <= 1'b0;
            issue_cnt <= '0;
            cap_cnt   <= '0;
          end else begin
            if (issue_cnt < len_n) begin
              mem_a_o   <= next_addr_c;
              issue_cnt <= issue_cnt + CNT_W'(1);
            end else begin
              mem_a_o <= IDLE_ADDR;
            end
            // Read data trails its address by one cycle, so capture starts one edge late
            if (!cap_arm) begin
              cap_arm <= 1'b1;
            end else begin
              word_buf <= cap_word_c;
              cap_cnt  <= cap_cnt + CNT_W'(1);
              if (cap_cnt == len_n - CNT_W'(1)) begin
                state <= DONE;
                if (src_dm) begin
                  dm_rdata_o <= cap_word_c;
                  dm_done_o  <= 1'b1;
                end else begin
                  if_inst_o <= cap_word_c;
                  if_done_o <= 1'b1;
                end
              end
            end
          end
        end
        WR: begin
          if (issue_cnt < len_n) begin
            mem_a_o    <= next_addr_c;
            mem_dout_o <= issue_byte_c;
            issue_cnt  <= issue_cnt + CNT_W'(1);
          end else begin
            state      <= DONE;
            mem_wr_o   <= 1'b0;
            mem_a_o    <= IDLE_ADDR;
            mem_dout_o <= '0;
            dm_done_o  <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          busy_o    <= 1'b0;
          issue_cnt <= '0;
          cap_cnt   <= '0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: byte memory, golden shadow memory, bus monitor,
// directed cases followed by randomized transactions with random rdy stalls.
module tb_mem_port_arbiter;

  localparam logic [31:0] IDLE_A = 32'hFFFF_FFF0;
  localparam int          MEM_N  = 4096;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in = 1'b1;
  logic        if_req_in;
  logic [31:0] if_addr_in;
  logic        if_done_o;
  logic [31:0] if_inst_o;
  logic        dm_req_in;
  logic        dm_we_in;
  logic [1:0]  dm_len_in;
  logic [31:0] dm_addr_in;
  logic [31:0] dm_wdata_in;
  logic        dm_done_o;
  logic [31:0] dm_rdata_o;
  logic        busy_o;
  logic [7:0]  mem_din_in;
  logic [7:0]  mem_dout_o;
  logic [31:0] mem_a_o;
  logic        mem_wr_o;
`ifdef MEM_ARB_IF_FLUSH_EN
  logic        if_flush_in;
`endif

  mem_port_arbiter #(.ADDR_WIDTH(32), .IDLE_ADDR(IDLE_A)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in),
`ifdef MEM_ARB_IF_FLUSH_EN
    .if_flush_in(if_flush_in),
`endif
    .if_done_o(if_done_o), .if_inst_o(if_inst_o),
    .dm_req_in(dm_req_in), .dm_we_in(dm_we_in), .dm_len_in(dm_len_in),
    .dm_addr_in(dm_addr_in), .dm_wdata_in(dm_wdata_in),
    .dm_done_o(dm_done_o), .dm_rdata_o(dm_rdata_o), .busy_o(busy_o),
    .mem_din_in(mem_din_in), .mem_dout_o(mem_dout_o), .mem_a_o(mem_a_o), .mem_wr_o(mem_wr_o)
  );

  int n_checks;
  int n_fail;
  int cyc;
  int edge_cnt;
  int if_done_cnt;
  int dm_done_cnt;
  bit mem_clr;
  bit rand_stall;
  int stall_from;
  int bus_rd;
  logic [7:0]  env_mem [0:MEM_N-1];
  logic [7:0]  gold    [0:MEM_N-1];
  logic [40:0] bus_q [$];
  logic [40:0] exp_q [$];

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] pat(input int unsigned a);
    return 8'((a * 37 + 11) ^ (a >> 4));
  endfunction

  function automatic int len_bytes(input logic [1:0] l);
    return (l == 2'd0) ? 1 : (l == 2'd1) ? 2 : 4;
  endfunction

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Free-running cycle count, count of rdy-qualified edges and completed done pulses
  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (rdy_in) edge_cnt <= edge_cnt + 1;
    if (rdy_in && rst_in && if_done_o) if_done_cnt <= if_done_cnt + 1;
    if (rdy_in && rst_in && dm_done_o) dm_done_cnt <= dm_done_cnt + 1;
  end

  // Global ready: a directed 3-cycle window plus optional random stalls
  always @(posedge clk_in) begin
    #1;
    rdy_in = !((cyc >= stall_from) && (cyc < stall_from + 3)) &&
             (!rand_stall || ($urandom_range(0, 3) != 0));
  end

  // Byte memory: read data appears the cycle after its address, frozen with rdy
  always @(posedge clk_in) begin
    if (mem_clr) begin
      for (int i = 0; i < MEM_N; i++) env_mem[i] <= pat(i);
    end else if (rdy_in) begin
      mem_din_in <= env_mem[mem_a_o[11:0]];
      if (mem_wr_o) env_mem[mem_a_o[11:0]] <= mem_dout_o;
    end
  end

  // Bus monitor: every cycle whose edge commits a bus beat
  always @(negedge clk_in) begin
    if (rst_in && rdy_in && (mem_a_o != IDLE_A || mem_wr_o))
      bus_q.push_back({mem_a_o, mem_wr_o, mem_wr_o ? mem_dout_o : 8'h00});
  end

  task automatic expect_bus(input logic [31:0] addr, input int ln, input bit we, input logic [31:0] wd);
    for (int k = 0; k < ln; k++)
      exp_q.push_back({addr + 32'(k), we, we ? 8'(wd >> (8 * k)) : 8'h00});
  endtask

  task automatic check_bus();
    int n;
    n = bus_q.size() - bus_rd;
    chk_eq("bus_beats", 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n; i++)
      chk_eq("bus_beat", 64'(bus_q[bus_rd + i]), 64'(exp_q[i]));
    bus_rd = bus_q.size();
    exp_q.delete();
  endtask

  task automatic wait_idle();
    @(posedge clk_in); #1;
    for (int i = 0; i < 200 && busy_o; i++) begin
      @(posedge clk_in); #1;
    end
  endtask

  task automatic run_txn(input bit is_dm, input bit we, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input bit chk_lat, input int stall_off, output int cycles);
    int ln, s, c0;
    bit got;
    logic [31:0] exp;
    logic [11:0] idx;
    ln  = is_dm ? len_bytes(len) : 4;
    exp = '0;
    for (int k = 0; k < ln; k++) begin
      idx = 12'(addr + 32'(k));
      if (is_dm && we) gold[idx] = 8'(wd >> (8 * k));
      else             exp = exp | (32'(gold[idx]) << (8 * k));
    end
    wait_idle();
    if (is_dm) begin
      dm_req_in = 1'b1; dm_we_in = we; dm_len_in = len; dm_addr_in = addr; dm_wdata_in = wd;
    end else begin
      if_req_in = 1'b1; if_addr_in = addr;
    end
    s  = edge_cnt;
    c0 = cyc;
    if (stall_off > 0) stall_from = c0 + stall_off;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk_in);
      got = is_dm ? dm_done_o : if_done_o;
    end
    if (is_dm) dm_req_in = 1'b0;
    else       if_req_in = 1'b0;
    cycles = cyc - c0;
    chk_eq(is_dm ? "dm_done_seen" : "if_done_seen", 64'(got), 64'(1));
    if (chk_lat)
      chk_eq(is_dm ? "dm_latency" : "if_latency", 64'(edge_cnt - s), 64'((is_dm && we) ? ln + 1 : ln + 2));
    if (!(is_dm && we))
      chk_eq(is_dm ? "dm_rdata" : "if_inst", 64'(is_dm ? dm_rdata_o : if_inst_o), 64'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int cy, d0, s;
    bit got, isdm, we;
    logic [1:0]  len;
    logic [31:0] addr, wd;
    n_checks = 0; n_fail = 0; bus_rd = 0;
    rand_stall = 1'b0; stall_from = 1_000_000_000;
    rst_in = 1'b0; mem_clr = 1'b1;
    if_req_in = 1'b0; if_addr_in = '0;
    dm_req_in = 1'b0; dm_we_in = 1'b0; dm_len_in = '0; dm_addr_in = '0; dm_wdata_in = '0;
`ifdef MEM_ARB_IF_FLUSH_EN
    if_flush_in = 1'b0;
`endif
    for (int i = 0; i < MEM_N; i++) gold[i] = pat(i);

    repeat (3) @(posedge clk_in);
    #1 mem_clr = 1'b0;
    @(negedge clk_in);
    chk_eq("rst_mem_a", 64'(mem_a_o), 64'(IDLE_A));
    chk_eq("rst_mem_wr", 64'(mem_wr_o), 64'(0));
    chk_eq("rst_mem_dout", 64'(mem_dout_o), 64'(0));
    chk_eq("rst_if_done", 64'(if_done_o), 64'(0));
    chk_eq("rst_dm_done", 64'(dm_done_o), 64'(0));
    chk_eq("rst_if_inst", 64'(if_inst_o), 64'(0));
    chk_eq("rst_dm_rdata", 64'(dm_rdata_o), 64'(0));
    chk_eq("rst_busy", 64'(busy_o), 64'(0));
    @(posedge clk_in); #1 rst_in = 1'b1;
    bus_rd = bus_q.size();

    // Instruction word stored, then DEADBEEF store, then fetch back
    expect_bus(32'h100, 4, 1'b1, 32'h0010_0513);
    run_txn(1'b1, 1'b1, 2'd3, 32'h100, 32'h0010_0513, 1'b1, 0, cy);
    check_bus();
    expect_bus(32'h200, 4, 1'b1, 32'hDEAD_BEEF);
    run_txn(1'b1, 1'b1, 2'd3, 32'h200, 32'hDEAD_BEEF, 1'b1, 0, cy);
    chk_eq("store4_done_cycle", 64'(cy), 64'(5));
    check_bus();
    expect_bus(32'h100, 4, 1'b0, 32'h0);
    run_txn(1'b0, 1'b0, 2'd0, 32'h100, 32'h0, 1'b1, 0, cy);
    chk_eq("fetch_done_cycle", 64'(cy), 64'(6));
    chk_eq("fetch_word", 64'(if_inst_o), 64'(32'h0010_0513));
    check_bus();

    // Simultaneous requests: DM first, its address seen once, then IF
    expect_bus(32'h30000, 1, 1'b1, 32'h41);
    run_txn(1'b1, 1'b1, 2'd0, 32'h30000, 32'h41, 1'b1, 0, cy);
    chk_eq("store1_done_cycle", 64'(cy), 64'(2));
    check_bus();
    expect_bus(32'h30000, 1, 1'b0, 32'h0);
    expect_bus(32'h200, 4, 1'b0, 32'h0);
    fork
      run_txn(1'b1, 1'b0, 2'd0, 32'h30000, 32'h0, 1'b1, 0, cy);
      begin int cy2; run_txn(1'b0, 1'b0, 2'd0, 32'h200, 32'h0, 1'b0, 0, cy2); end
    join
    chk_eq("tie_dm_rdata", 64'(dm_rdata_o), 64'(32'h41));
    chk_eq("tie_if_inst", 64'(if_inst_o), 64'(32'hDEAD_BEEF));
    check_bus();

    // Fetch with rdy low in cycles 3..5
    expect_bus(32'h100, 4, 1'b0, 32'h0);
    run_txn(1'b0, 1'b0, 2'd0, 32'h100, 32'h0, 1'b1, 3, cy);
    chk_eq("stall_done_cycle", 64'(cy), 64'(9));
    check_bus();

    // Address wrap and the 2'd2 length code
    expect_bus(32'hFFFF_FFFE, 4, 1'b1, 32'hA1B2_C3D4);
    run_txn(1'b1, 1'b1, 2'd3, 32'hFFFF_FFFE, 32'hA1B2_C3D4, 1'b1, 0, cy);
    expect_bus(32'hFFFF_FFFF, 2, 1'b0, 32'h0);
    run_txn(1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0, 1'b1, 0, cy);
    expect_bus(32'hFFFF_FFFD, 4, 1'b0, 32'h0);
    run_txn(1'b1, 1'b0, 2'd2, 32'hFFFF_FFFD, 32'h0, 1'b1, 0, cy);
    check_bus();

    // Reset during cycle 2 of a store: only byte 0 committed, no done
    wait_idle();
    d0 = dm_done_cnt;
    dm_req_in = 1'b1; dm_we_in = 1'b1; dm_len_in = 2'd3; dm_addr_in = 32'h400; dm_wdata_in = 32'h1122_3344;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    #1;
    chk_eq("midrst_mem_wr", 64'(mem_wr_o), 64'(0));
    chk_eq("midrst_mem_a", 64'(mem_a_o), 64'(IDLE_A));
    chk_eq("midrst_busy", 64'(busy_o), 64'(0));
    chk_eq("midrst_dm_rdata", 64'(dm_rdata_o), 64'(0));
    dm_req_in = 1'b0;
    @(posedge clk_in); #1 rst_in = 1'b1;
    @(negedge clk_in);
    chk_eq("midrst_no_done", 64'(dm_done_cnt - d0), 64'(0));
    gold[12'h400] = 8'h44;
    expect_bus(32'h400, 1, 1'b1, 32'h44);
    check_bus();
    expect_bus(32'h400, 4, 1'b0, 32'h0);
    run_txn(1'b1, 1'b0, 2'd3, 32'h400, 32'h0, 1'b1, 0, cy);
    check_bus();

`ifdef MEM_ARB_IF_FLUSH_EN
    // Flush in cycle 3 of a fetch, with a load waiting behind it
    wait_idle();
    d0 = if_done_cnt;
    if_req_in = 1'b1; if_addr_in = 32'h100;
    repeat (3) begin @(posedge clk_in); #1; end
    if_flush_in = 1'b1; if_req_in = 1'b0;
    dm_req_in = 1'b1; dm_we_in = 1'b0; dm_len_in = 2'd3; dm_addr_in = 32'h200;
    @(posedge clk_in); #1;
    if_flush_in = 1'b0;
    s = edge_cnt;
    @(negedge clk_in);
    chk_eq("flush_idle", 64'(busy_o), 64'(0));
    chk_eq("flush_mem_a", 64'(mem_a_o), 64'(IDLE_A));
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk_in);
      got = dm_done_o;
    end
    dm_req_in = 1'b0;
    chk_eq("flush_dm_done", 64'(got), 64'(1));
    chk_eq("flush_dm_latency", 64'(edge_cnt - s), 64'(6));
    chk_eq("flush_dm_rdata", 64'(dm_rdata_o), 64'(32'hDEAD_BEEF));
    chk_eq("flush_no_if_done", 64'(if_done_cnt - d0), 64'(0));
    expect_bus(32'h100, 3, 1'b0, 32'h0);
    expect_bus(32'h200, 4, 1'b0, 32'h0);
    check_bus();
`endif

    // Randomized traffic under random stalls
    rand_stall = 1'b1;
    for (int t = 0; t < 60; t++) begin
      isdm = ($urandom_range(0, 2) != 0);
      we   = isdm && ($urandom_range(0, 1) == 1);
      len  = 2'($urandom_range(0, 3));
      addr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                         : 32'($urandom) & 32'h000F_FFFF;
      wd   = 32'($urandom);
      expect_bus(addr, isdm ? len_bytes(len) : 4, we, wd);
      run_txn(isdm, we, len, addr, wd, 1'b1, 0, cy);
      check_bus();
    end
    rand_stall = 1'b0;
    repeat (4) @(posedge clk_in);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Owns the CPU's single byte-wide memory bus and shares it between two requesters:
  - instruction fetch (IF), which always reads 4 bytes;
  - data memory (DM, load/store), which reads or writes 1, 2 or 4 bytes.
- Serialises each request into byte transfers and assembles/disassembles 32-bit little-endian words.
- Sits between the pipeline stages and the top-level memory pins; the top-level port drives mem_din/mem_dout/mem_a/mem_wr directly from it.

Parameters:
- ADDR_WIDTH, 32, width of all address ports.
- IDLE_ADDR, 32'h0, address driven on mem_a_o while not transferring; must lie outside I/O space.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- rdy_in  input  1  global ready; low freezes all state
- if_req_in  input  1  fetch request, held until if_done_o
- if_addr_in  input  ADDR_WIDTH  fetch address
- if_done_o  output  1  one-cycle pulse, if_inst_o valid
- if_inst_o  output  32  fetched word
- dm_req_in  input  1  data request, held until dm_done_o
- dm_we_in  input  1  1 = store, 0 = load
- dm_len_in  input  2  0 = 1 B, 1 = 2 B, 3 = 4 B; value 2 is treated as 4 B
- dm_addr_in  input  ADDR_WIDTH  data address
- dm_wdata_in  input  32  store data; byte k = bits[8k+7:8k]
- dm_done_o  output  1  one-cycle pulse on completion
- dm_rdata_o  output  32  load data, zero-extended above the length
- busy_o  output  1  high in any non-IDLE state
- mem_din_in  input  8  memory read byte
- mem_dout_o  output  8  memory write byte
- mem_a_o  output  ADDR_WIDTH  memory address
- mem_wr_o  output  1  1 = write

Behaviour:
- Reset (rst_in low, async):
  - state IDLE, counters 0.
  - mem_a_o = IDLE_ADDR, mem_wr_o = 0, mem_dout_o = 0.
  - if_done_o = dm_done_o = 0, if_inst_o = dm_rdata_o = 0, busy_o = 0.
  - A transfer interrupted mid-way is abandoned and no done is issued; mem_wr_o drops immediately.
- rdy_in low:
  - No register changes, including counters, outputs and captured bytes.
  - The memory subsystem is frozen by the same signal, so mem_din_in stays stable.
- States: IDLE, RD, WR, DONE.
  - All outputs are registered.
  - Byte counter issue_cnt and capture counter cap_cnt are 3 bits wide.
  - len_n = 1, 2 or 4.
- IDLE:
  - At an edge with dm_req_in high, accept DM; otherwise, with if_req_in high, accept IF.
  - DM has fixed priority on a tie. No preemption once a transfer has started.
  - Request fields are latched on acceptance.
- Memory timing:
  - Write: one byte per cycle.
  - Read: the byte for the address on mem_a_o in cycle c appears on mem_din_in in cycle c+1 and is sampled at the end of c+1.
- RD (acceptance edge = E0):
  - mem_a_o = base + k during cycle k+1, for k = 0..len_n-1.
  - mem_din_in is sampled at edges E2..E(len_n+1) into byte cap_cnt.
  - After the last address, mem_a_o returns to IDLE_ADDR. Each address is presented exactly once, so I/O reads are never duplicated.
  - At edge E(len_n+1), go to DONE.
- WR:
  - mem_wr_o = 1, mem_a_o = base + k, mem_dout_o = byte k during cycle k+1.
  - At edge E(len_n), go to DONE with mem_wr_o = 0.
- DONE:
  - Exactly one cycle long; the matching done output is high and data outputs are valid.
  - The data outputs hold their value until the next completion of the same port.
  - Then IDLE.
  - The requester must drop req during the done cycle. A req still high at the next edge starts a new transaction.
- Address arithmetic: base + k wraps modulo 2^ADDR_WIDTH. No alignment check.
- Latencies (acceptance to done pulse): 4 B read = 6 cycles; 1 B read = 3; 4 B write = 5; 1 B write = 2.

Optional Feature:
- Macro: MEM_ARB_IF_FLUSH_EN.
- When defined:
  - Adds input if_flush_in (1 bit).
  - During an IF transfer in RD, flush forces the next state to IDLE and mem_a_o to IDLE_ADDR.
  - No if_done_o is issued; captured bytes are discarded.
  - In IDLE, flush blocks IF acceptance that cycle.
  - Flush has no effect on DM transfers.
- When undefined: the port is absent and IF transfers always complete.

Test Plan:
- IF only, if_addr_in = 0x100, memory bytes 0x13,0x05,0x10,0x00 -> mem_a_o steps 0x100..0x103 in cycles 1-4; if_done_o pulses in cycle 6; if_inst_o = 0x00100513.
- DM store, len = 3, addr = 0x200, wdata = 0xDEADBEEF -> mem_wr_o high for 4 cycles with bytes EF,BE,AD,DE at 0x200..0x203; dm_done_o in cycle 5.
- dm_req_in and if_req_in raised at the same edge (DM load len = 0 at 0x30000 returning 0x41) -> DM runs first; dm_rdata_o = 0x00000041; 0x30000 appears on mem_a_o exactly once; IF starts after DM returns to IDLE.
- 4 B read with rdy_in held low for 3 cycles after cycle 2 -> mem_a_o and counters frozen; result identical to the unstalled run, with done delayed by 3 cycles.
- rst_in pulsed low during cycle 2 of a store -> mem_wr_o = 0 and mem_a_o = IDLE_ADDR immediately; no dm_done_o; next request completes normally.
- With MEM_ARB_IF_FLUSH_EN defined, if_flush_in asserted in cycle 3 of a fetch -> no if_done_o; state IDLE next cycle; a pending DM request is accepted the following edge.
